id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use hazard detection,
//                bubble insertion on stall/flush, and combinational EX/MEM
//                and MEM/WB operand forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    // decode stage
    input  logic              id_valid,
    input  logic [2:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic [AW-1:0]     id_rs_addr,
    input  logic [AW-1:0]     id_rt_addr,
    input  logic [AW-1:0]     id_rd_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    // forwarding sources
    input  logic              mem_reg_write,
    input  logic [AW-1:0]     mem_rd_addr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [AW-1:0]     wb_rd_addr,
    input  logic [DATA_W-1:0] wb_result,
    // execute stage
    output logic              ex_valid,
    output logic [2:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_operand1,
    output logic [DATA_W-1:0] ex_operand2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [AW-1:0]     ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              stall
);

    // pipeline register contents
    logic              r_valid;
    logic [2:0]        r_alu_op;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic              r_alu_src;
    logic [AW-1:0]     r_rs_addr;
    logic [AW-1:0]     r_rt_addr;
    logic [AW-1:0]     r_rd_addr;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;

    logic              w_stall;
    logic              w_bubble;
    logic              w_rt_used;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // rt is a true source unless it only names the destination of an
    // immediate-form instruction; stores always read it as data.
    assign w_rt_used = !id_alu_src || id_mem_write;

    // Load-use hazard: the load in EX produces its value too late for the
    // dependent instruction in ID, so hold ID one cycle. A flush wins.
    always_comb begin
        w_stall = 1'b0;
        if (id_valid && r_valid && r_mem_read && (r_rd_addr != '0) && !flush) begin
            if ((r_rd_addr == id_rs_addr) ||
                ((r_rd_addr == id_rt_addr) && w_rt_used))
                w_stall = 1'b1;
        end
    end

    assign w_bubble = flush || w_stall;
    assign stall    = w_stall;

    // Capture the decoded instruction, or load an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_alu_op    <= 3'b000;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (w_bubble) begin
            r_valid     <= 1'b0;
            r_alu_op    <= 3'b000;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_rs_addr   <= '0;
            r_rt_addr   <= '0;
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_valid     <= id_valid;
            r_alu_op    <= id_alu_op;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_alu_src   <= id_alu_src;
            r_rs_addr   <= id_rs_addr;
            r_rt_addr   <= id_rt_addr;
            r_rd_addr   <= id_rd_addr;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
        end
    end

    // Forward rs: the youngest producer (EX/MEM) wins; r0 is never forwarded.
    always_comb begin
        w_fwd_rs = r_rs_data;
        if (r_rs_addr != '0) begin
            if (mem_reg_write && (mem_rd_addr == r_rs_addr))
                w_fwd_rs = mem_result;
            else if (wb_reg_write && (wb_rd_addr == r_rs_addr))
                w_fwd_rs = wb_result;
        end
    end

    // Forward rt with the same priority as rs.
    always_comb begin
        w_fwd_rt = r_rt_data;
        if (r_rt_addr != '0) begin
            if (mem_reg_write && (mem_rd_addr == r_rt_addr))
                w_fwd_rt = mem_result;
            else if (wb_reg_write && (wb_rd_addr == r_rt_addr))
                w_fwd_rt = wb_result;
        end
    end

    assign ex_operand1   = w_fwd_rs;
    assign ex_operand2   = r_alu_src ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;

    // control outputs straight from flops
    assign ex_valid     = r_valid;
    assign ex_alu_op    = r_alu_op;
    assign ex_rd_addr   = r_rd_addr;
    assign ex_reg_write = r_reg_write;
    assign ex_mem_read  = r_mem_read;
    assign ex_mem_write = r_mem_write;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Scoreboard bench for id_ex_stage with directed hazard
//                scenarios followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int AW     = 5;
    localparam int N_RAND = 400;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [2:0]        id_alu_op;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic              id_alu_src;
    logic [AW-1:0]     id_rs_addr, id_rt_addr, id_rd_addr;
    logic              id_reg_write, id_mem_read, id_mem_write;
    logic              flush;
    logic              mem_reg_write;
    logic [AW-1:0]     mem_rd_addr;
    logic [DATA_W-1:0] mem_result;
    logic              wb_reg_write;
    logic [AW-1:0]     wb_rd_addr;
    logic [DATA_W-1:0] wb_result;
    logic              ex_valid;
    logic [2:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_operand1, ex_operand2, ex_store_data;
    logic [AW-1:0]     ex_rd_addr;
    logic              ex_reg_write, ex_mem_read, ex_mem_write;
    logic              stall;

    id_ex_stage #(.DATA_W(DATA_W), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An instruction as seen by the EX stage (a bubble is the all-zero one).
    typedef struct {
        logic              valid;
        logic [2:0]        op;
        logic [DATA_W-1:0] rs_data, rt_data, imm;
        logic              alu_src;
        logic [AW-1:0]     rs, rt, rd;
        logic              rw, mr, mw;
    } instr_t;

    // Expected externally visible values for one cycle.
    typedef struct {
        logic              valid, rw, mr, mw, stall;
        logic [2:0]        op;
        logic [AW-1:0]     rd;
        logic [DATA_W-1:0] op1, op2, st;
    } exp_t;

    instr_t m_ex;
    exp_t   sb_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic instr_t bubble();
        instr_t b;
        b.valid = 0; b.op = 0; b.rs_data = 0; b.rt_data = 0; b.imm = 0;
        b.alu_src = 0; b.rs = 0; b.rt = 0; b.rd = 0; b.rw = 0; b.mr = 0; b.mw = 0;
        return b;
    endfunction

    // Value of register `a` as EX should see it: newest pending write wins.
    function automatic logic [DATA_W-1:0] fwd(input logic [AW-1:0] a, input logic [DATA_W-1:0] rf);
        if (a == 0) return rf;
        if (mem_reg_write && mem_rd_addr == a) return mem_result;
        if (wb_reg_write && wb_rd_addr == a) return wb_result;
        return rf;
    endfunction

    function automatic logic load_use_hazard();
        logic rt_src;
        rt_src = !id_alu_src || id_mem_write;
        return id_valid && m_ex.valid && m_ex.mr && m_ex.rd != 0 && !flush &&
               (m_ex.rd == id_rs_addr || (m_ex.rd == id_rt_addr && rt_src));
    endfunction

    task automatic set_ins(input logic v, input logic [2:0] op,
                           input logic [DATA_W-1:0] rsd, rtd, imm, input logic src,
                           input logic [AW-1:0] rs, rt, rd,
                           input logic rw, mr, mw);
        id_valid = v; id_alu_op = op; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_src = src; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic set_fwd(input logic mrw, input logic [AW-1:0] mrd, input logic [DATA_W-1:0] mres,
                           input logic wrw, input logic [AW-1:0] wrd, input logic [DATA_W-1:0] wres);
        mem_reg_write = mrw; mem_rd_addr = mrd; mem_result = mres;
        wb_reg_write = wrw; wb_rd_addr = wrd; wb_result = wres;
    endtask

    // Inputs for this cycle are in place: publish expectation, advance one edge.
    task automatic step();
        exp_t   e;
        instr_t nxt;
        e.valid = m_ex.valid; e.rw = m_ex.rw; e.mr = m_ex.mr; e.mw = m_ex.mw;
        e.op = m_ex.op; e.rd = m_ex.rd;
        e.op1 = fwd(m_ex.rs, m_ex.rs_data);
        e.st  = fwd(m_ex.rt, m_ex.rt_data);
        e.op2 = m_ex.alu_src ? m_ex.imm : e.st;
        e.stall = load_use_hazard();
        sb_q.push_back(e);
        if (flush || e.stall) nxt = bubble();
        else begin
            nxt.valid = id_valid; nxt.op = id_alu_op; nxt.rs_data = id_rs_data;
            nxt.rt_data = id_rt_data; nxt.imm = id_imm; nxt.alu_src = id_alu_src;
            nxt.rs = id_rs_addr; nxt.rt = id_rt_addr; nxt.rd = id_rd_addr;
            nxt.rw = id_reg_write; nxt.mr = id_mem_read; nxt.mw = id_mem_write;
        end
        @(posedge clk); #1;
        m_ex = nxt;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, ex_valid, 0);
        chk({tag, "_ctl"}, {ex_reg_write, ex_mem_read, ex_mem_write}, 0);
        chk({tag, "_op"}, ex_alu_op, 0);
        chk({tag, "_rd"}, ex_rd_addr, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_data"}, {ex_operand1, ex_operand2}, 0);
        chk({tag, "_store"}, ex_store_data, 0);
    endtask

    // Monitor: compare DUT against the oldest expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ex_valid", ex_valid, e.valid);
                chk("ex_alu_op", ex_alu_op, e.op);
                chk("ex_rd_addr", ex_rd_addr, e.rd);
                chk("ex_ctl", {ex_reg_write, ex_mem_read, ex_mem_write}, {e.rw, e.mr, e.mw});
                chk("ex_operand1", ex_operand1, e.op1);
                chk("ex_operand2", ex_operand2, e.op2);
                chk("ex_store_data", ex_store_data, e.st);
                chk("stall", stall, e.stall);
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 0;
        set_fwd(0, 0, 0, 0, 0, 0);
        m_ex = bubble();
        #1;
        chk_reset_state("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // ADD r3 = r1 + r2, no hazards
        set_ins(1, 3'b010, 5, 7, 32'h99, 0, 1, 2, 3, 1, 0, 0); step();
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // EX reads r1 while MEM and WB both write r1: MEM value wins
        set_ins(1, 3'b010, 32'h1, 32'h2, 0, 0, 1, 6, 7, 1, 0, 0); step();
        set_fwd(1, 1, 32'h20, 1, 1, 32'h10);
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_fwd(0, 1, 32'h20, 1, 1, 32'h10); step();   // WB only now
        set_fwd(0, 0, 0, 0, 0, 0);

        // LW r4 then SUB r6 = r4 - r2: one-cycle stall, bubble, then SUB
        set_ins(1, 3'b010, 32'h100, 0, 32'h8, 1, 9, 4, 4, 1, 1, 0); step();
        set_ins(1, 3'b110, 32'h55, 32'h66, 0, 0, 4, 2, 6, 1, 0, 0); step();
        step(); step();
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

        // LW r4 then ADDI r5, r4 (rs match) -> stall
        set_ins(1, 3'b010, 32'h100, 0, 32'h8, 1, 9, 4, 4, 1, 1, 0); step();
        set_ins(1, 3'b010, 32'h11, 32'h22, 32'h3, 1, 4, 5, 5, 1, 0, 0); step();
        step();
        // LW r4 then immediate op with rt=r4 only as destination -> no stall
        set_ins(1, 3'b010, 32'h100, 0, 32'h8, 1, 9, 4, 4, 1, 1, 0); step();
        set_ins(1, 3'b010, 32'h11, 32'h22, 32'h3, 1, 7, 4, 4, 1, 0, 0); step();

        // rs = r0 with MEM writing r0: no forwarding
        set_ins(1, 3'b101, 32'hABC, 32'h1, 0, 0, 0, 0, 2, 1, 0, 0); step();
        set_fwd(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_fwd(0, 0, 0, 0, 0, 0);

        // flush during a would-be stall: bubble, stall=0
        set_ins(1, 3'b010, 32'h100, 0, 32'h8, 1, 9, 4, 4, 1, 1, 0); step();
        set_ins(1, 3'b110, 32'h55, 32'h66, 0, 0, 4, 2, 6, 1, 0, 0);
        flush = 1; step(); flush = 0; step();

        // randomized traffic
        for (int i = 0; i < N_RAND; i++) begin
            set_ins(($urandom_range(0, 9) != 0), 3'($urandom), $urandom, $urandom, $urandom,
                    1'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
            flush = ($urandom_range(0, 9) == 0);
            set_fwd(1'($urandom), AW'($urandom_range(0, 7)), $urandom,
                    1'($urandom), AW'($urandom_range(0, 7)), $urandom);
            step();

            // asynchronous reset pulse mid-stream
            if (i == N_RAND / 2) begin
                @(negedge clk);   // let the monitor drain the last expectation
                set_ins(1, 3'b111, 32'h1, 32'h2, 32'h3, 0, 1, 2, 3, 1, 1, 1);
                set_fwd(0, 0, 0, 0, 0, 0);
                flush = 0;
                #1 rst_n = 1'b0;
                #1 chk_reset_state("async_rst");
                @(posedge clk); #1;
                chk_reset_state("rst_hold");
                rst_n = 1'b1;
                m_ex = bubble();
            end
        end

        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 0;
        set_fwd(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
